// File: rtl/alu_decode_stage.sv
// Decode stage for RV32I OP / OP-IMM words feeding the ALU.
// Decodes on entry and holds results in a 2-entry output/skid buffer with a registered ready.
module alu_decode_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_inst,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [2:0]        o_op_sel,
   output logic              o_sub,
   output logic [1:0]        o_bool_op,
   output logic [1:0]        o_cmp,
   output logic              o_shift_right,
   output logic              o_shift_arith,
   output logic              o_use_imm,
   output logic [XLEN-1:0]   o_imm,
   output logic [REG_AW-1:0] o_rs1,
   output logic [REG_AW-1:0] o_rs2,
   output logic [REG_AW-1:0] o_rd,
   output logic              o_illegal
);

   typedef struct packed {
      logic [2:0]        op_sel;
      logic              sub;
      logic [1:0]        bool_op;
      logic [1:0]        cmp;
      logic              shift_right;
      logic              shift_arith;
      logic              use_imm;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } dec_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t       d;
      logic [6:0] f7;
      logic [2:0] f3;
      logic       imm_form;
      logic       legal;
      d        = '0;
      f7       = inst[31:25];
      f3       = inst[14:12];
      imm_form = 1'b0;
      legal    = 1'b0;
      // Register indices and immediate come from raw bits even for illegal words
      d.imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      d.rs1 = REG_AW'(inst[19:15]);
      d.rs2 = REG_AW'(inst[24:20]);
      d.rd  = REG_AW'(inst[11:7]);
      case (inst[6:0])
         7'b0110011: begin
            legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         7'b0010011: begin
            imm_form = 1'b1;
            case (f3)
               3'b001:  legal = (f7 == 7'b0000000);
               3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               default: legal = 1'b1;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if (legal) begin
         d.use_imm = imm_form;
         case (f3)
            3'b000: begin
               d.op_sel = 3'b001;
               d.sub    = !imm_form && inst[30];
            end
            3'b001: d.op_sel = 3'b010;
            3'b010: begin
               d.op_sel = 3'b001;
               d.sub    = 1'b1;
               d.cmp    = 2'b10;
            end
            3'b011: begin
               d.op_sel = 3'b001;
               d.sub    = 1'b1;
               d.cmp    = 2'b11;
            end
            3'b100: begin
               d.op_sel  = 3'b100;
               d.bool_op = 2'b00;
            end
            3'b101: begin
               d.op_sel      = 3'b010;
               d.shift_right = 1'b1;
               d.shift_arith = inst[30];
            end
            3'b110: begin
               d.op_sel  = 3'b100;
               d.bool_op = 2'b10;
            end
            3'b111: begin
               d.op_sel  = 3'b100;
               d.bool_op = 2'b11;
            end
            default: d.illegal = 1'b1;
         endcase
      end else begin
         d.illegal = 1'b1;
      end
      return d;
   endfunction

   state_t state_r;
   dec_t   out_r;
   dec_t   skid_r;
   dec_t   dec_s;
   logic   valid_r;
   logic   ready_r;
   logic   in_fire_s;
   logic   out_fire_s;

   // Decode the incoming word and qualify both handshakes
   always_comb begin
      dec_s      = decode(i_inst);
      in_fire_s  = i_valid && ready_r;
      out_fire_s = valid_r && i_ready;
   end

   // Buffer occupancy FSM with registered valid/ready and payload registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_EMPTY;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         out_r   <= '0;
         skid_r  <= '0;
      end else if (i_flush) begin
         state_r <= ST_EMPTY;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  out_r   <= dec_s;
                  valid_r <= 1'b1;
                  state_r <= ST_ONE;
               end
            end
            ST_ONE: begin
               case ({in_fire_s, out_fire_s})
                  2'b10: begin
                     skid_r  <= dec_s;
                     ready_r <= 1'b0;
                     state_r <= ST_TWO;
                  end
                  2'b01: begin
                     valid_r <= 1'b0;
                     state_r <= ST_EMPTY;
                  end
                  2'b11: out_r <= dec_s;
                  default: out_r <= out_r;
               endcase
            end
            ST_TWO: begin
               // Older entry leaves first; the skid entry moves up in order
               if (out_fire_s) begin
                  out_r   <= skid_r;
                  ready_r <= 1'b1;
                  state_r <= ST_ONE;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign o_valid       = valid_r;
   assign o_ready       = ready_r;
   assign o_op_sel      = out_r.op_sel;
   assign o_sub         = out_r.sub;
   assign o_bool_op     = out_r.bool_op;
   assign o_cmp         = out_r.cmp;
   assign o_shift_right = out_r.shift_right;
   assign o_shift_arith = out_r.shift_arith;
   assign o_use_imm     = out_r.use_imm;
   assign o_imm         = out_r.imm;
   assign o_rs1         = out_r.rs1;
   assign o_rs2         = out_r.rs2;
   assign o_rd          = out_r.rd;
   assign o_illegal     = out_r.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed vector table, stall/flush/reset
// sequences, and random traffic against a queue-based reference model.
module tb_alu_decode_stage;

   typedef struct packed {
      logic [2:0]  op_sel;
      logic        sub;
      logic [1:0]  bool_op;
      logic [1:0]  cmp;
      logic        sr;
      logic        sa;
      logic        ui;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [2:0] SEL_TAB [8] = '{3'b001, 3'b010, 3'b001, 3'b001,
                                         3'b100, 3'b010, 3'b100, 3'b100};

   logic        i_clk = 1'b0;
   logic        i_rst, i_flush, i_valid, i_ready;
   logic [31:0] i_inst;
   logic        o_ready, o_valid, o_sub, o_shift_right, o_shift_arith, o_use_imm, o_illegal;
   logic [2:0]  o_op_sel;
   logic [1:0]  o_bool_op, o_cmp;
   logic [31:0] o_imm;
   logic [4:0]  o_rs1, o_rs2, o_rd;

   int total = 0;
   int bad   = 0;

   alu_decode_stage #(.XLEN(32), .REG_AW(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_inst(i_inst), .o_valid(o_valid), .i_ready(i_ready),
      .o_op_sel(o_op_sel), .o_sub(o_sub), .o_bool_op(o_bool_op), .o_cmp(o_cmp),
      .o_shift_right(o_shift_right), .o_shift_arith(o_shift_arith),
      .o_use_imm(o_use_imm), .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_rd(o_rd), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   // Reference decode written from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         is_op, is_imm, ok;
      e      = '0;
      f3     = w[14:12];
      f7     = w[31:25];
      e.imm  = {{20{w[31]}}, w[31:20]};
      e.rs1  = w[19:15];
      e.rs2  = w[24:20];
      e.rd   = w[11:7];
      is_op  = (w[6:0] == OPC_OP);
      is_imm = (w[6:0] == OPC_IMM);
      if (is_op)
         ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      else if (is_imm)
         ok = (f3 == 3'd1) ? (f7 == 7'h00) :
              (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      else
         ok = 1'b0;
      e.ill = !ok;
      if (ok) begin
         e.op_sel  = SEL_TAB[f3];
         e.ui      = is_imm;
         e.cmp     = (f3 == 3'd2) ? 2'b10 : (f3 == 3'd3) ? 2'b11 : 2'b00;
         e.sub     = (e.cmp != 2'b00) || (is_op && f3 == 3'd0 && w[30]);
         e.bool_op = (e.op_sel == 3'b100) ? f3[1:0] : 2'b00;
         e.sr      = (f3 == 3'd5);
         e.sa      = (f3 == 3'd5) && w[30];
      end
      return e;
   endfunction

   function automatic exp_t got();
      exp_t a;
      a = '{o_op_sel, o_sub, o_bool_op, o_cmp, o_shift_right, o_shift_arith,
            o_use_imm, o_imm, o_rs1, o_rs2, o_rd, o_illegal};
      return a;
   endfunction

   task automatic chk_dec(input string nm, input exp_t want);
      exp_t a;
      a = got();
      total++;
      if (a !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, a, want);
      end
   endtask

   task automatic chk_bit(input string nm, input logic a, input logic want);
      total++;
      if (a !== want) begin
         bad++;
         $display("FAIL %s: got=%b want=%b", nm, a, want);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   vec_t vt [14];
   exp_t q [$];

   initial begin
      logic [31:0] w;
      logic [6:0]  f7;
      logic [6:0]  opc;
      bit          in_f, out_f, fl;

      vt[0]  = '{32'h002081B3, '{3'b001, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000002, 5'd1, 5'd2, 5'd3, 1'b0}};
      vt[1]  = '{32'h402081B3, '{3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000402, 5'd1, 5'd2, 5'd3, 1'b0}};
      vt[2]  = '{32'hFFF0C193, '{3'b100, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd1, 5'd31, 5'd3, 1'b0}};
      vt[3]  = '{mk(7'h20, 5'd5, 5'd1, 3'b101, 5'd3, OPC_IMM), '{3'b010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 32'h00000405, 5'd1, 5'd5, 5'd3, 1'b0}};
      vt[4]  = '{mk(7'h20, 5'd5, 5'd1, 3'b001, 5'd3, OPC_IMM), '{3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000405, 5'd1, 5'd5, 5'd3, 1'b1}};
      vt[5]  = '{mk(7'h00, 5'd4, 5'd2, 3'b010, 5'd7, OPC_LD), '{3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000004, 5'd2, 5'd4, 5'd7, 1'b1}};
      vt[6]  = '{32'h0020B1B3, '{3'b001, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 32'h00000002, 5'd1, 5'd2, 5'd3, 1'b0}};
      vt[7]  = '{mk(7'h7F, 5'd31, 5'd2, 3'b010, 5'd4, OPC_IMM), '{3'b001, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd4, 1'b0}};
      vt[8]  = '{mk(7'h00, 5'd6, 5'd5, 3'b111, 5'd8, OPC_OP), '{3'b100, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000006, 5'd5, 5'd6, 5'd8, 1'b0}};
      vt[9]  = '{mk(7'h20, 5'd2, 5'd3, 3'b110, 5'd9, OPC_OP), '{3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000402, 5'd3, 5'd2, 5'd9, 1'b1}};
      vt[10] = '{mk(7'h20, 5'd7, 5'd6, 3'b101, 5'd10, OPC_OP), '{3'b010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h00000407, 5'd6, 5'd7, 5'd10, 1'b0}};
      vt[11] = '{mk(7'h01, 5'd3, 5'd4, 3'b001, 5'd5, OPC_OP), '{3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000023, 5'd4, 5'd3, 5'd5, 1'b1}};
      vt[12] = '{mk(7'h00, 5'd2, 5'd1, 3'b101, 5'd1, OPC_IMM), '{3'b010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h00000002, 5'd1, 5'd2, 5'd1, 1'b0}};
      vt[13] = '{mk(7'h20, 5'd0, 5'd2, 3'b000, 5'd6, OPC_IMM), '{3'b001, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h00000400, 5'd2, 5'd0, 5'd6, 1'b0}};

      i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_inst = 32'h0;
      repeat (3) tick();
      chk_dec("reset_fields", '0);
      chk_bit("reset_valid", o_valid, 1'b0);
      chk_bit("reset_ready", o_ready, 1'b1);
      i_rst = 1'b0;
      tick();

      // Directed vectors, one at a time with downstream always ready
      for (int i = 0; i < 14; i++) begin
         i_valid = 1'b1; i_inst = vt[i].inst; i_ready = 1'b1;
         tick();
         i_valid = 1'b0;
         chk_bit($sformatf("vec%0d_valid", i), o_valid, 1'b1);
         chk_dec($sformatf("vec%0d_dec", i), vt[i].e);
         tick();
         chk_bit($sformatf("vec%0d_drain", i), o_valid, 1'b0);
      end

      // Stall: three offered back-to-back, only two accepted, drained in order
      i_ready = 1'b0;
      i_valid = 1'b1; i_inst = vt[0].inst;
      tick();
      chk_bit("stall_ready1", o_ready, 1'b1);
      i_inst = vt[1].inst;
      tick();
      chk_bit("stall_ready2", o_ready, 1'b0);
      i_inst = vt[2].inst;
      tick();
      chk_bit("stall_ready3", o_ready, 1'b0);
      chk_dec("stall_hold", vt[0].e);
      i_valid = 1'b0; i_ready = 1'b1;
      tick();
      chk_bit("drain_ready", o_ready, 1'b1);
      chk_bit("drain_valid1", o_valid, 1'b1);
      chk_dec("drain_second", vt[1].e);
      tick();
      chk_bit("drain_empty", o_valid, 1'b0);

      // Flush while full with an input offered
      i_ready = 1'b0; i_valid = 1'b1; i_inst = vt[3].inst;
      tick();
      i_inst = vt[4].inst;
      tick();
      chk_bit("pre_flush_ready", o_ready, 1'b0);
      i_flush = 1'b1; i_inst = vt[5].inst; i_valid = 1'b1;
      tick();
      i_flush = 1'b0; i_valid = 1'b0;
      chk_bit("flush_valid", o_valid, 1'b0);
      chk_bit("flush_ready", o_ready, 1'b1);
      tick();
      chk_bit("flush_discard", o_valid, 1'b0);

      // Reset mid-stall
      i_valid = 1'b1; i_inst = vt[6].inst;
      tick();
      i_inst = vt[7].inst;
      tick();
      i_valid = 1'b0; i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk_dec("rst_stall_fields", '0);
      chk_bit("rst_stall_valid", o_valid, 1'b0);
      chk_bit("rst_stall_ready", o_ready, 1'b1);

      // Random traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         chk_bit("rnd_valid", o_valid, q.size() > 0);
         chk_bit("rnd_ready", o_ready, q.size() < 2);
         if (q.size() > 0) chk_dec("rnd_dec", q[0]);
         w = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: opc = OPC_OP;
            4, 5, 6, 7: opc = OPC_IMM;
            default:    opc = 7'($urandom_range(0, 127));
         endcase
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: f7 = 7'h00;
            6, 7:             f7 = 7'h20;
            default:          f7 = 7'($urandom_range(0, 127));
         endcase
         w[6:0]   = opc;
         w[31:25] = f7;
         i_inst  = w;
         i_valid = ($urandom_range(0, 9) < 7);
         i_ready = ($urandom_range(0, 9) < 6);
         fl      = ($urandom_range(0, 39) == 0);
         i_flush = fl;
         in_f    = i_valid && (q.size() < 2);
         out_f   = i_ready && (q.size() > 0);
         if (out_f) void'(q.pop_front());
         if (fl) q.delete();
         else if (in_f) q.push_back(ref_decode(w));
         tick();
      end
      i_flush = 1'b0; i_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
